// File: rtl/softmax_max_sub.sv
// Frame buffer + running max ahead of the softmax exponent lanes; emits x_i - max as a vector.
// Optional in_last framing check enabled by defining SOFTMAX_MAXSUB_LAST_CHECK_EN.
module softmax_max_sub #(
  parameter int DATA_W = 17,
  parameter int N      = 5,
  parameter int CNT_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N*DATA_W-1:0]      out_vec,
  output logic signed [DATA_W-1:0] out_max
`ifdef SOFTMAX_MAXSUB_LAST_CHECK_EN
  ,
  input  logic                     in_last,
  output logic                     frame_err
`endif
);

  // state   | meaning
  // COLLECT | accepting beats, tracking running max
  // CALC    | one cycle: subtract max, saturate, register vector
  // HOLD    | vector presented until downstream accepts
  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_CALC    = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;

  localparam logic signed [DATA_W:0]   SAT_MIN_W = {2'b11, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]               r_state;
  logic [CNT_W-1:0]         r_count;
  logic signed [DATA_W-1:0] r_buf [N];
  logic signed [DATA_W-1:0] r_run_max;
  logic [N*DATA_W-1:0]      r_out_vec;
  logic signed [DATA_W-1:0] r_out_max;
  logic                     r_out_valid;

  logic                     w_hs;
  logic                     w_last_beat;
  logic                     w_abort;
  logic                     w_out_hs;
  logic signed [DATA_W:0]   w_diff_wide [N];
  logic [N*DATA_W-1:0]      w_diff_vec;

  assign w_hs        = in_valid & (r_state == S_COLLECT);
  assign w_last_beat = (r_count == CNT_W'(N-1));
  assign w_out_hs    = r_out_valid & out_ready;

`ifdef SOFTMAX_MAXSUB_LAST_CHECK_EN
  // An early in_last drops the partial frame; a missing one only flags the error.
  assign w_abort = w_hs & in_last & ~w_last_beat;
`else
  assign w_abort = 1'b0;
`endif

  // Difference is formed one bit wider so the subtraction itself never wraps.
  always_comb begin
    w_diff_vec = '0;
    for (int i = 0; i < N; i++) begin
      w_diff_wide[i] = {r_buf[i][DATA_W-1], r_buf[i]} - {r_run_max[DATA_W-1], r_run_max};
      if (w_diff_wide[i] < SAT_MIN_W)
        w_diff_vec[i*DATA_W +: DATA_W] = SAT_MIN;
      else
        w_diff_vec[i*DATA_W +: DATA_W] = w_diff_wide[i][DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_COLLECT;
      r_count     <= '0;
      r_run_max   <= '0;
      r_out_vec   <= '0;
      r_out_max   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          if (w_abort) begin
            r_count <= '0;
          end else if (w_hs) begin
            if (r_count == '0 || in_data > r_run_max)
              r_run_max <= in_data;
            if (w_last_beat) begin
              r_count <= '0;
              r_state <= S_CALC;
            end else begin
              r_count <= r_count + CNT_W'(1);
            end
          end
        end
        S_CALC: begin
          r_out_vec   <= w_diff_vec;
          r_out_max   <= r_run_max;
          r_out_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_state     <= S_COLLECT;
          end
        end
        default: begin
          r_state     <= S_COLLECT;
          r_count     <= '0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Buffer contents are don't-care after reset, so it carries no reset term.
  always_ff @(posedge clk) begin
    if (w_hs && !w_abort)
      r_buf[r_count] <= in_data;
  end

`ifdef SOFTMAX_MAXSUB_LAST_CHECK_EN
  logic r_frame_err;

  always_ff @(posedge clk) begin
    if (rst)
      r_frame_err <= 1'b0;
    else if (w_hs && (in_last != w_last_beat))
      r_frame_err <= 1'b1;
  end

  assign frame_err = r_frame_err;
`endif

  assign in_ready  = (r_state == S_COLLECT);
  assign out_valid = r_out_valid;
  assign out_vec   = r_out_vec;
  assign out_max   = r_out_max;

endmodule

// File: tb/tb_softmax_max_sub.sv
// Scoreboard bench for softmax_max_sub: directed plus random frames against a max-subtract model.
module tb_softmax_max_sub;

  localparam int DW   = 17;
  localparam int NE   = 5;
  localparam int SMIN = -65536;
  localparam int SMAX = 65535;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [NE*DW-1:0]     out_vec;
  logic signed [DW-1:0] out_max;
`ifdef SOFTMAX_MAXSUB_LAST_CHECK_EN
  logic                 in_last = 1'b0;
  logic                 frame_err;
`endif

  softmax_max_sub #(.DATA_W(DW), .N(NE), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_max   (out_max)
`ifdef SOFTMAX_MAXSUB_LAST_CHECK_EN
    ,
    .in_last   (in_last),
    .frame_err (frame_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int d [NE];
    int mx;
  } exp_t;

  exp_t q_exp [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ready_mode = 0;  // 0: always ready, 1: random, 2: forced low

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: max by value, subtract, clamp below at the most negative code.
  function automatic exp_t model(input int v [NE]);
    exp_t e;
    e.mx = v[0];
    foreach (v[i]) if (v[i] > e.mx) e.mx = v[i];
    foreach (v[i]) begin
      e.d[i] = v[i] - e.mx;
      if (e.d[i] < SMIN) e.d[i] = SMIN;
    end
    return e;
  endfunction

  // Monitor: pops on each output handshake and checks the hold-side protocol.
  bit                   prev_hs    = 0;
  bit                   prev_valid = 0;
  logic [NE*DW-1:0]     prev_vec;
  logic signed [DW-1:0] prev_max;

  always @(negedge clk) begin
    if (rst) begin
      prev_hs    = 0;
      prev_valid = 0;
    end else begin
      if (prev_hs) chk(out_valid == 1'b0, "valid_drop_after_hs", out_valid, 0);
      if (out_valid) chk(in_ready == 1'b0, "in_ready_while_held", in_ready, 0);
      if (prev_valid && !prev_hs) begin
        chk(out_valid == 1'b1, "valid_held", out_valid, 1);
        chk(out_vec == prev_vec, "vec_stable", 64'(out_vec), 64'(prev_vec));
        chk(out_max == prev_max, "max_stable", out_max, prev_max);
      end
      if (out_valid && out_ready) begin
        if (q_exp.size() == 0) begin
          chk(0, "unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = q_exp.pop_front();
          for (int i = 0; i < NE; i++) begin
            int a;
            a = int'($signed(out_vec[i*DW +: DW]));
            chk(a == e.d[i], $sformatf("out_vec[%0d]", i), a, e.d[i]);
          end
          chk(int'(out_max) == e.mx, "out_max", out_max, e.mx);
        end
      end
      prev_hs    = out_valid && out_ready;
      prev_valid = out_valid;
      prev_vec   = out_vec;
      prev_max   = out_max;
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic send_beat(input int val, input bit last);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_data  = val[DW-1:0];
`ifdef SOFTMAX_MAXSUB_LAST_CHECK_EN
    in_last  = last;
`endif
    n = 0;
    acc = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk(0, "beat_accept_timeout", 0, 1);
    in_valid = 1'b0;
`ifdef SOFTMAX_MAXSUB_LAST_CHECK_EN
    in_last  = 1'b0;
`endif
  endtask

  task automatic send_frame(input int v [NE], input int gap);
    for (int i = 0; i < NE; i++) begin
      if (gap == 1 && i > 0) begin
        @(posedge clk); #1;
      end else if (gap == 2) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      if (i == NE-1) q_exp.push_back(model(v));
      send_beat(v[i], i == NE-1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q_exp.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(q_exp.size() == 0, "drain", q_exp.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int fr [NE];

  initial begin
    do_reset();
    @(negedge clk);
    chk(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
    chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
    chk(out_vec == '0, "rst_out_vec", 64'(out_vec), 0);
    chk(out_max == '0, "rst_out_max", out_max, 0);
    @(posedge clk); #1;

    fr = '{3, -2, 7, 7, 0};            send_frame(fr, 0);
    fr = '{SMAX, SMIN, 0, 0, 0};       send_frame(fr, 0);
    drain();

    // Backpressure: hold six cycles, offer a beat that must not be taken.
    ready_mode = 2;
    fr = '{-5, -5, -5, -5, -5};        send_frame(fr, 0);
    in_valid = 1'b1; in_data = 17'sd99;
    repeat (6) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    ready_mode = 0;
    drain();

    // Reset mid-frame aborts the partial frame.
    send_beat(100, 0); send_beat(200, 0); send_beat(300, 0);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    fr = '{1, 2, 3, 4, 5};             send_frame(fr, 0);
    drain();

    fr = '{10, 20, 30, 40, 50};        send_frame(fr, 1);
    drain();

`ifdef SOFTMAX_MAXSUB_LAST_CHECK_EN
    @(negedge clk);
    chk(frame_err == 1'b0, "frame_err_clean", frame_err, 0);
    @(posedge clk); #1;
    send_beat(-1, 0); send_beat(-2, 0); send_beat(-3, 1);
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    chk(frame_err == 1'b1, "frame_err_early_last", frame_err, 1);
    @(posedge clk); #1;
    fr = '{4, 8, 2, 6, 1};             send_frame(fr, 0);
    drain();
    @(negedge clk);
    chk(frame_err == 1'b1, "frame_err_sticky", frame_err, 1);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk(frame_err == 1'b0, "frame_err_rst", frame_err, 0);
    @(posedge clk); #1;
`endif

    ready_mode = 1;
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < NE; i++) begin
        case ($urandom_range(0, 7))
          0: fr[i] = SMIN;
          1: fr[i] = SMAX;
          default: fr[i] = int'($urandom_range(0, 131071)) - 65536;
        endcase
      end
      send_frame(fr, 2);
    end
    ready_mode = 0;
    drain();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
